uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the shared baud tick generator. It detects a start bit on the serial line, qualifies it at mid-bit, and pulses align so the external baud generator's ticks land at bit centres. It gates the generator's enable while a frame is in progress, shifts in the data bits LSB-first, and checks the stop bit. It sits between the pad-side rx line and the byte-level consumer.

---
 rtl/uart_rx_ctrl_if.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive sequencer, the shared baud tick
// generator and the byte-level consumer.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 baud_tick;
  logic                 baud_en;
  logic                 baud_align;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  rx,
    input  baud_tick,
    output baud_en,
    output baud_align,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

  modport master (
    output rx,
    output baud_tick,
    input  baud_en,
    input  baud_align,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer: qualifies the start bit at mid-bit, aligns the shared
// baud generator to bit centres, shifts data in LSB-first and checks the stop bit.
module uart_rx_ctrl #(
  parameter int CLK_FREQ_HZ = 1_600_000,
  parameter int BAUD_RATE   = 100_000,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF    = DIVISOR / 2;
  localparam int HCNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIDX_W  = $clog2(DATA_BITS + 1);

  localparam logic [HCNT_W-1:0] HALF_M1   = HCNT_W'(HALF - 1);
  localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;

  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 align_q, align_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;

  // Metastability chain; presets high so reset looks like an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      align_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      align_q <= align_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    data_d  = data_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    align_d = 1'b0;
    en_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // After a framing error the line must return high before re-arming,
        // otherwise a held break would retrigger forever.
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          state_d = START;
          hcnt_d  = '0;
        end
      end

      START: begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HALF_M1) begin
          if (!rx_s) begin
            align_d = 1'b1;
            en_d    = 1'b1;
            bidx_d  = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        en_d = 1'b1;
        if (bus.baud_tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == LAST_BIT) state_d = STOP;
        end
      end

      STOP: begin
        en_d = 1'b1;
        if (bus.baud_tick) begin
          en_d    = 1'b0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            armed_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.baud_en    = en_q;
  assign bus.baud_align = align_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the baud generator and checks received words
// against a queue of frames the bench itself sent.
module tb_uart_rx_ctrl;

  localparam int DIV = 16;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(8)) u_if ();

  uart_rx_ctrl #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE  (100_000),
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  exp_t expq[$];
  logic [7:0] ref_data = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gen_cnt = 0;
  int n_align = 0, n_valid = 0, n_err = 0, n_en = 0, n_busy = 0;
  int last_strobe_cyc = 0;
  logic prev_valid = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: observe registered outputs, then drive rx and the modelled
  // generator's tick for the next rising edge.
  task automatic step(input logic rxv);
    exp_t e;
    logic tick;
    @(negedge clk);
    cyc++;
    if (u_if.baud_align) n_align++;
    if (u_if.baud_en) n_en++;
    if (u_if.busy) n_busy++;
    if (u_if.data_valid || u_if.frame_err) begin
      chk("strobe_exclusive", int'(u_if.data_valid & u_if.frame_err), 0);
      chk("strobe_width", int'((u_if.data_valid & prev_valid) | (u_if.frame_err & prev_err)), 0);
      chk("busy_before_strobe", int'(prev_busy), 1);
      chk("busy_at_strobe", int'(u_if.busy), 0);
      chk("en_at_strobe", int'(u_if.baud_en), 0);
      last_strobe_cyc = cyc;
      if (u_if.data_valid) n_valid++;
      else n_err++;
      chk("strobe_expected", int'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("strobe_kind_err", int'(u_if.frame_err), int'(e.err));
        if (!e.err) ref_data = e.data;
      end
      chk("data_out_at_strobe", int'(u_if.data_out), int'(ref_data));
    end
    prev_valid = u_if.data_valid;
    prev_err   = u_if.frame_err;
    prev_busy  = u_if.busy;

    u_if.rx = rxv;
    tick = u_if.baud_en && !u_if.baud_align && (gen_cnt == DIV - 1);
    u_if.baud_tick = tick;
    if (u_if.baud_align) gen_cnt = 0;
    else if (u_if.baud_en) gen_cnt = (gen_cnt == DIV - 1) ? 0 : gen_cnt + 1;
    else gen_cnt = 0;
  endtask

  task automatic hold(input logic v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    expq.push_back(e);
    hold(1'b0, BIT);
    for (int b = 0; b < 8; b++) hold(d[b], BIT);
    hold(stop, BIT);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_baud_en"}, int'(u_if.baud_en), 0);
    chk({tag, "_baud_align"}, int'(u_if.baud_align), 0);
    chk({tag, "_data_valid"}, int'(u_if.data_valid), 0);
    chk({tag, "_frame_err"}, int'(u_if.frame_err), 0);
    chk({tag, "_busy"}, int'(u_if.busy), 0);
    chk({tag, "_data_out"}, int'(u_if.data_out), 0);
  endtask

  initial begin
    vec_t tbl[4];
    int strobe_t[4];
    int a0, v0, e0, en0, b0;
    logic [7:0] rd;
    logic rs;
    int nframes;

    u_if.rx = 1'b1;
    u_if.baud_tick = 1'b0;

    // Reset state
    hold(1'b1, 3);
    chk_outputs_zero("reset");
    rst = 1'b0;
    hold(1'b1, 2 * BIT);

    // Good frame, bad stop, back-to-back pair
    tbl[0] = '{data: 8'hA5, stop: 1'b1, gap_bits: 2, exp_valid: 1, exp_err: 0, exp_dout: 8'hA5};
    tbl[1] = '{data: 8'h3C, stop: 1'b0, gap_bits: 2, exp_valid: 0, exp_err: 1, exp_dout: 8'hA5};
    tbl[2] = '{data: 8'h00, stop: 1'b1, gap_bits: 0, exp_valid: 1, exp_err: 0, exp_dout: 8'h00};
    tbl[3] = '{data: 8'hFF, stop: 1'b1, gap_bits: 2, exp_valid: 1, exp_err: 0, exp_dout: 8'hFF};
    for (int i = 0; i < 4; i++) begin
      a0 = n_align; v0 = n_valid; e0 = n_err;
      send_frame(tbl[i].data, tbl[i].stop);
      hold(1'b1, tbl[i].gap_bits * BIT);
      strobe_t[i] = last_strobe_cyc;
      chk($sformatf("vec%0d_align_count", i), n_align - a0, 1);
      chk($sformatf("vec%0d_valid_count", i), n_valid - v0, tbl[i].exp_valid);
      chk($sformatf("vec%0d_err_count", i), n_err - e0, tbl[i].exp_err);
      chk($sformatf("vec%0d_data_out", i), int'(u_if.data_out), int'(tbl[i].exp_dout));
    end
    chk("b2b_strobe_spacing", strobe_t[3] - strobe_t[2], 10 * BIT);

    // False start: glitch of 3 cycles
    a0 = n_align; v0 = n_valid; e0 = n_err; en0 = n_en; b0 = n_busy;
    hold(1'b0, 3);
    hold(1'b1, 2 * BIT);
    chk("false_start_align", n_align - a0, 0);
    chk("false_start_en", n_en - en0, 0);
    chk("false_start_strobes", (n_valid - v0) + (n_err - e0), 0);
    chk("false_start_busy_seen", int'(n_busy > b0), 1);
    chk("false_start_idle", int'(u_if.busy), 0);

    // Asynchronous reset during data bit 3 of 0x5A
    rd = 8'h5A;
    hold(1'b0, BIT);
    for (int b = 0; b < 3; b++) hold(rd[b], BIT);
    hold(rd[3], BIT / 2);
    chk("pre_rst_en", int'(u_if.baud_en), 1);
    chk("pre_rst_busy", int'(u_if.busy), 1);
    chk("pre_rst_data_out", int'(u_if.data_out), 8'hFF);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("async_rst");
    hold(1'b1, 3);
    rst = 1'b0;
    ref_data = 8'h00;
    expq.delete();
    hold(1'b1, 2 * BIT);
    v0 = n_valid;
    send_frame(8'h81, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("post_rst_valid", n_valid - v0, 1);
    chk("post_rst_data_out", int'(u_if.data_out), 8'h81);

    // Break: rx held low for 40 bit times
    a0 = n_align; v0 = n_valid; e0 = n_err;
    begin
      exp_t e;
      e.err = 1'b1;
      e.data = 8'h00;
      expq.push_back(e);
    end
    hold(1'b0, 40 * BIT);
    chk("break_err_count", n_err - e0, 1);
    chk("break_align_count", n_align - a0, 1);
    chk("break_valid_count", n_valid - v0, 0);
    chk("break_busy", int'(u_if.busy), 0);
    chk("break_data_out", int'(u_if.data_out), 8'h81);
    hold(1'b1, 2 * BIT);
    send_frame(8'h42, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("after_break_valid", n_valid - v0, 1);
    chk("after_break_data_out", int'(u_if.data_out), 8'h42);

    // Randomised frames against the expectation queue
    a0 = n_align;
    nframes = 40;
    for (int i = 0; i < nframes; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rs);
      if (!rs) hold(1'b1, BIT * $urandom_range(1, 2) + $urandom_range(0, 5));
      else hold(1'b1, BIT * $urandom_range(0, 2) + $urandom_range(0, 5));
    end
    hold(1'b1, 2 * BIT);
    chk("random_align_count", n_align - a0, nframes);
    chk("random_queue_drained", expq.size(), 0);
    chk("random_idle", int'(u_if.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
